// File: rtl/vpg_mode_selector.sv
// Video mode selector: debounced pushbutton cycles through five video modes, drives the
// PLL reconfiguration request and holds the timing generator in reset until lock settles.
// Latency: press acts 1 clk after the debounced edge; mode_change rises 1 clk after mode.
// Backpressure: none; presses seen outside RUN are dropped, never queued.
//
// Ports:
//   clk          50 MHz reference clock (shared with pll_controller)
//   reset_n      asynchronous active-low reset
//   key_n        raw pushbutton, active-low, asynchronous to clk
//   pll_locked   raw pixel PLL lock, asynchronous to clk
//   mode         current mode code for pll_controller
//   mode_change  reconfiguration request pulse, PULSE_CYCLES wide
//   mode_idx     current mode index 0..4
//   vpg_reset_n  active-low reset to the video timing generator (high only in RUN)
//   busy         high in every state except RUN
//   lock_error   sticky flag, set when a lock wait times out
module vpg_mode_selector #(
  parameter int DEBOUNCE_CYCLES     = 500000,
  parameter int PULSE_CYCLES        = 8,
  parameter int LOCK_TIMEOUT_CYCLES = 1048576,
  parameter int SETTLE_CYCLES       = 1024,
  parameter int INIT_MODE           = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_n,
  input  logic       pll_locked,
  output logic [3:0] mode,
  output logic       mode_change,
  output logic [2:0] mode_idx,
  output logic       vpg_reset_n,
  output logic       busy,
  output logic       lock_error
);

  // Mode codes, same values as the vpg.h macros of the same names.
  localparam logic [3:0] VGA_640x480p60   = 4'd0;
  localparam logic [3:0] MODE_720x480     = 4'd1;
  localparam logic [3:0] MODE_1024x768    = 4'd2;
  localparam logic [3:0] MODE_1280x1024   = 4'd3;
  localparam logic [3:0] FHD_1920x1080p60 = 4'd4;

  localparam logic [2:0] LAST_IDX = 3'd4;
  localparam logic [2:0] INIT_IDX = (INIT_MODE > 4 || INIT_MODE < 0) ? 3'd0 : 3'(INIT_MODE);

  // Each counter only ever needs to hold its terminal value (parameter - 1).
  localparam int DB_W  = (DEBOUNCE_CYCLES     > 1) ? $clog2(DEBOUNCE_CYCLES)     : 1;
  localparam int TO_W  = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;
  localparam int SET_W = (SETTLE_CYCLES       > 1) ? $clog2(SETTLE_CYCLES)       : 1;
  // The pulse counter counts 0..PULSE_CYCLES, one beyond the others.
  localparam int PUL_W = $clog2(PULSE_CYCLES + 1);

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [PUL_W-1:0] PUL_END  = PUL_W'(PULSE_CYCLES);

  typedef enum logic [2:0] {
    ST_CHANGE      = 3'd0,
    ST_WAIT_UNLOCK = 3'd1,
    ST_WAIT_LOCK   = 3'd2,
    ST_SETTLE      = 3'd3,
    ST_RUN         = 3'd4
  } state_t;

  function automatic logic [3:0] f_mode_code(input logic [2:0] idx);
    logic [3:0] code;
    case (idx)
      3'd0:    code = VGA_640x480p60;
      3'd1:    code = MODE_720x480;
      3'd2:    code = MODE_1024x768;
      3'd3:    code = MODE_1280x1024;
      3'd4:    code = FHD_1920x1080p60;
      default: code = VGA_640x480p60;
    endcase
    return code;
  endfunction

  //--------------------------------------------------------------------------
  // Two-flop synchronisers. The key idles released (1), the lock idles low
  // so nothing downstream believes in lock straight out of reset.
  //--------------------------------------------------------------------------
  logic r_key_meta, r_key_s;
  logic r_lock_meta, r_lock_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_key_meta  <= 1'b1;
      r_key_s     <= 1'b1;
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_key_meta  <= key_n;
      r_key_s     <= r_key_meta;
      r_lock_meta <= pll_locked;
      r_lock_s    <= r_lock_meta;
    end
  end

  //--------------------------------------------------------------------------
  // Debouncer: the stable level follows key_s only after key_s has differed
  // from it for DEBOUNCE_CYCLES consecutive clocks. Runs in every FSM state.
  //--------------------------------------------------------------------------
  logic            r_key_stable;
  logic [DB_W-1:0] r_db_cnt;
  logic            r_press;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_key_stable <= 1'b1;
      r_db_cnt     <= '0;
      r_press      <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (r_key_s == r_key_stable) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_key_stable <= r_key_s;
        r_db_cnt     <= '0;
        // key_s differs from the old level, so an old level of 1 means a 1->0 edge.
        r_press      <= r_key_stable;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  //--------------------------------------------------------------------------
  // Mode / lock sequencing FSM with registered outputs.
  //--------------------------------------------------------------------------
  state_t           r_state;
  logic [2:0]       r_mode_idx;
  logic [3:0]       r_mode;
  logic             r_mode_change;
  logic             r_vpg_reset_n;
  logic             r_busy;
  logic             r_lock_error;
  logic [PUL_W-1:0] r_pulse_cnt;
  logic [TO_W-1:0]  r_tmr;
  logic [SET_W-1:0] r_settle_cnt;
  logic [2:0]       w_next_idx;

  assign w_next_idx = (r_mode_idx >= LAST_IDX) ? 3'd0 : r_mode_idx + 3'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // Starting in CHANGE makes the initial mode get programmed after every reset.
      r_state       <= ST_CHANGE;
      r_mode_idx    <= INIT_IDX;
      r_mode        <= f_mode_code(INIT_IDX);
      r_mode_change <= 1'b0;
      r_vpg_reset_n <= 1'b0;
      r_busy        <= 1'b1;
      r_lock_error  <= 1'b0;
      r_pulse_cnt   <= '0;
      r_tmr         <= '0;
      r_settle_cnt  <= '0;
    end else begin
      case (r_state)
        ST_CHANGE: begin
          // mode was registered on entry, so it is stable a clock before the rise.
          if (r_pulse_cnt == PUL_END) begin
            r_mode_change <= 1'b0;
            r_tmr         <= '0;
            r_state       <= ST_WAIT_UNLOCK;
          end else begin
            r_mode_change <= 1'b1;
            r_pulse_cnt   <= r_pulse_cnt + 1'b1;
          end
        end

        ST_WAIT_UNLOCK: begin
          // A reconfiguration that never drops lock is legal: just move on.
          if (!r_lock_s || r_tmr == TO_LAST) begin
            r_tmr   <= '0;
            r_state <= ST_WAIT_LOCK;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end

        ST_WAIT_LOCK: begin
          if (r_lock_s) begin
            r_settle_cnt <= '0;
            r_state      <= ST_SETTLE;
          end else if (r_tmr == TO_LAST) begin
            // Retry the same mode indefinitely; the flag records that it happened.
            r_lock_error <= 1'b1;
            r_pulse_cnt  <= '0;
            r_state      <= ST_CHANGE;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end

        ST_SETTLE: begin
          if (!r_lock_s) begin
            r_tmr   <= '0;
            r_state <= ST_WAIT_LOCK;
          end else if (r_settle_cnt == SET_LAST) begin
            r_vpg_reset_n <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= ST_RUN;
          end else begin
            r_settle_cnt <= r_settle_cnt + 1'b1;
          end
        end

        ST_RUN: begin
          // A press wins over a simultaneous lock loss: reprogramming covers both.
          if (r_press) begin
            r_mode_idx    <= w_next_idx;
            r_mode        <= f_mode_code(w_next_idx);
            r_vpg_reset_n <= 1'b0;
            r_busy        <= 1'b1;
            r_pulse_cnt   <= '0;
            r_state       <= ST_CHANGE;
          end else if (!r_lock_s) begin
            r_vpg_reset_n <= 1'b0;
            r_busy        <= 1'b1;
            r_tmr         <= '0;
            r_state       <= ST_WAIT_LOCK;
          end
        end

        default: begin
          r_mode_change <= 1'b0;
          r_vpg_reset_n <= 1'b0;
          r_busy        <= 1'b1;
          r_pulse_cnt   <= '0;
          r_state       <= ST_CHANGE;
        end
      endcase
    end
  end

  assign mode        = r_mode;
  assign mode_change = r_mode_change;
  assign mode_idx    = r_mode_idx;
  assign vpg_reset_n = r_vpg_reset_n;
  assign busy        = r_busy;
  assign lock_error  = r_lock_error;

endmodule

// File: doc/vpg_mode_selector.md
Name: vpg_mode_selector

Overview:
- Upstream of pll_controller in the video pattern generator.
- Turns a pushbutton into a cycled video mode selection and drives `mode`/`mode_change` for the PLL reconfiguration sequencer.
- Monitors the pixel PLL lock and holds the downstream timing generator in reset until the reconfigured clock is stable.
- Mode codes are the vpg.h macros.

Parameters:
- DEBOUNCE_CYCLES, 500000: clocks the key must be stable (10 ms at 50 MHz).
- PULSE_CYCLES, 8: width of the `mode_change` high pulse in clocks; minimum 3.
- LOCK_TIMEOUT_CYCLES, 1048576: maximum clocks spent waiting in either lock-wait state.
- SETTLE_CYCLES, 1024: clocks `pll_locked` must stay high before release.
- INIT_MODE, 0: mode index after reset, in the range 0..4.

Ports:
- clk, in, 1: 50 MHz reference clock, same clock as pll_controller.
- reset_n, in, 1: asynchronous, active-low reset.
- key_n, in, 1: pushbutton, active-low, asynchronous to clk.
- pll_locked, in, 1: pixel PLL lock, asynchronous to clk.
- mode, out, 4: current mode code, to pll_controller `mode`.
- mode_change, out, 1: reconfiguration request pulse, to pll_controller `mode_change`.
- mode_idx, out, 3: current mode index 0..4, for LEDs.
- vpg_reset_n, out, 1: active-low reset to the video timing generator.
- busy, out, 1: high in every state except RUN.
- lock_error, out, 1: sticky lock timeout flag.

Behaviour:
- Mode index map:
  - 0 = `VGA_640x480p60
  - 1 = `MODE_720x480
  - 2 = `MODE_1024x768
  - 3 = `MODE_1280x1024
  - 4 = `FHD_1920x1080p60
  - `mode` is registered from `mode_idx`; index values 5..7 are never produced.
- Synchronisers: `key_n` and `pll_locked` each pass through a 2-FF synchroniser (`key_s`, `lock_s`). All logic below uses the synchronised signals.
- Debounce:
  - A counter clears whenever `key_s` equals the stable level and increments otherwise.
  - When the counter reaches DEBOUNCE_CYCLES-1, the stable level takes `key_s` and the counter clears.
  - `press` is a one-cycle strobe on a 1->0 transition of the stable level.
  - Stable level resets to 1 (released).
- Reset values:
  - mode_idx = INIT_MODE and mode = code(INIT_MODE).
  - mode_change = 0, vpg_reset_n = 0, busy = 1, lock_error = 0.
  - State resets to CHANGE, so the initial mode is always programmed after reset.
- FSM states and transitions:
  - CHANGE:
    - `mode_change` is 1 for exactly PULSE_CYCLES clocks; the pulse starts in the first cycle spent in CHANGE.
    - `mode` is already stable at least 1 clock before `mode_change` rises.
    - When the pulse ends: `mode_change` = 0, timer clears, go to WAIT_UNLOCK.
  - WAIT_UNLOCK:
    - `lock_s` = 0: timer clears, go to WAIT_LOCK.
    - Timer reaches LOCK_TIMEOUT_CYCLES-1: go to WAIT_LOCK. This covers reconfiguration that never drops lock and is not an error.
  - WAIT_LOCK:
    - `lock_s` = 1: settle counter clears, go to SETTLE.
    - Timer reaches LOCK_TIMEOUT_CYCLES-1: lock_error <= 1 (sticky until reset_n), go to CHANGE and re-issue the same mode (unlimited retries).
  - SETTLE:
    - `lock_s` = 0: go to WAIT_LOCK with the timer cleared.
    - Settle counter reaches SETTLE_CYCLES-1 with `lock_s` still 1: go to RUN; vpg_reset_n <= 1 and busy <= 0 on entry.
  - RUN:
    - `press`: mode_idx <= (mode_idx == 4) ? 0 : mode_idx+1, mode updated, vpg_reset_n <= 0, busy <= 1, go to CHANGE. `mode_change` rises the following clock.
    - `lock_s` = 0 without a press: vpg_reset_n <= 0, go to WAIT_LOCK (no reconfiguration).
    - `press` and lock loss in the same cycle: press wins, go to CHANGE.
- Presses outside RUN are dropped, not queued. The debouncer keeps running in all states.
- vpg_reset_n is 0 in every state except RUN.
- Counters saturate at their terminal value and never wrap within a state.
- Assertion of reset_n in any state, including mid-pulse, returns all outputs to their reset values asynchronously. After release the block restarts with CHANGE for INIT_MODE.
- Width rules:
  - Debounce, lock timer and settle counters are each sized from their own parameter, at least 1 bit.
  - Comparisons use the full counter width.

Test Plan:
Bench parameters for all scenarios: DEBOUNCE_CYCLES=4, PULSE_CYCLES=3, LOCK_TIMEOUT_CYCLES=64, SETTLE_CYCLES=8.
1. Reset, then `pll_locked` falls 5 clocks after the pulse and rises 20 clocks later -> `mode_change` high exactly 3 clocks starting at the first post-reset clock, mode=`VGA_640x480p60; vpg_reset_n rises at lock_s + 8 clocks; busy=0; lock_error=0.
2. In RUN, key held low 10 clocks -> one press; mode_idx 0->1, mode=`MODE_720x480, vpg_reset_n=0 in the same clock, `mode_change` 3-clock pulse one clock later. Bounce of 3-clock glitches -> no press.
3. Five debounced presses from index 0, each completing lock -> sequence 1,2,3,4,0; the 5th press wraps to `VGA_640x480p60.
4. Press during WAIT_LOCK -> ignored (mode_idx unchanged). `pll_locked` held low past 64 clocks -> lock_error=1, a second `mode_change` pulse with the same mode. lock_error stays 1 after the eventual RUN.
5. `pll_locked` never drops after the pulse -> WAIT_UNLOCK times out after 64 clocks, SETTLE, RUN with lock_error=0. In SETTLE, a lock glitch at count 5 -> counter restarts and release is delayed by a full 8 clocks.
6. reset_n asserted in the 2nd pulse clock -> `mode_change`=0 and vpg_reset_n=0 immediately; mode_idx returns to INIT_MODE; after release a fresh 3-clock pulse occurs.
